gate_scheduler: RTL

GATE_SCHEDULER -- requirements
Module: gate_scheduler

---
 rtl/gate_scheduler.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/gate_scheduler.sv
// gate_scheduler: round-robin arbiter that time-shares one bitwise logic unit
// among N_REQ requesters; each result is held in OUT until the consumer takes it.
module gate_scheduler #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] x_bus,
  input  logic [N_REQ*WIDTH-1:0] y_bus,
  input  logic [N_REQ*2-1:0]     op_bus,
  output logic [N_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]       z,
  output logic                   z_valid,
  output logic [2:0]             z_id,
  input  logic                   z_ready,
  output logic                   busy,
  output logic [7:0]             ops_done
);

  // state   | meaning
  // S_IDLE  | waiting for any req; winner registered on exit
  // S_LATCH | gnt to winner for one cycle, its operands captured
  // S_EXEC  | shared logic unit evaluated into z
  // S_OUT   | z_valid held until z_ready
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LATCH = 2'd1,
    S_EXEC  = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  localparam logic [2:0] LAST_IDX = 3'(N_REQ - 1);

  state_t           r_state;
  state_t           w_next;
  logic [2:0]       r_ptr;
  logic [2:0]       r_win;
  logic [2:0]       r_z_id;
  logic [2:0]       w_pick;
  logic             w_hit;
  logic [3:0]       w_sum;
  logic [WIDTH-1:0] r_xa;
  logic [WIDTH-1:0] r_ya;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_z;
  logic [7:0]       r_ops_done;
  logic [WIDTH-1:0] w_x_sel;
  logic [WIDTH-1:0] w_y_sel;
  logic [1:0]       w_op_sel;
  logic [WIDTH-1:0] w_alu;
  logic             w_load_win;
  logic             w_capture;
  logic             w_exec;
  logic             w_accept;

  // Round-robin search: first set req bit at or after r_ptr, wrapping modulo N_REQ.
  always_comb begin
    w_pick = r_ptr;
    w_hit  = 1'b0;
    w_sum  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_sum = {1'b0, r_ptr} + 4'(k);
      if (w_sum >= 4'(N_REQ)) begin
        w_sum = w_sum - 4'(N_REQ);
      end
      for (int j = 0; j < N_REQ; j++) begin
        if (!w_hit && req[j] && (w_sum == 4'(j))) begin
          w_hit  = 1'b1;
          w_pick = 3'(j);
        end
      end
    end
  end

  always_comb begin
    w_x_sel  = '0;
    w_y_sel  = '0;
    w_op_sel = '0;
    for (int j = 0; j < N_REQ; j++) begin
      if (r_win == 3'(j)) begin
        w_x_sel  = x_bus[j*WIDTH +: WIDTH];
        w_y_sel  = y_bus[j*WIDTH +: WIDTH];
        w_op_sel = op_bus[j*2 +: 2];
      end
    end
  end

  always_comb begin
    case (r_op)
      2'b00:   w_alu = r_xa | r_ya;
      2'b01:   w_alu = r_xa & r_ya;
      2'b10:   w_alu = r_xa ^ r_ya;
      default: w_alu = ~(r_xa | r_ya);
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_load_win = 1'b0;
    w_capture  = 1'b0;
    w_exec     = 1'b0;
    w_accept   = 1'b0;
    gnt        = '0;
    z_valid    = 1'b0;
    busy       = 1'b1;
    case (r_state)
      S_IDLE: begin
        busy = 1'b0;
        if (w_hit) begin
          w_load_win = 1'b1;
          w_next     = S_LATCH;
        end
      end
      S_LATCH: begin
        for (int j = 0; j < N_REQ; j++) begin
          gnt[j] = (r_win == 3'(j));
        end
        w_capture = 1'b1;
        w_next    = S_EXEC;
      end
      S_EXEC: begin
        w_exec = 1'b1;
        w_next = S_OUT;
      end
      S_OUT: begin
        z_valid = 1'b1;
        if (z_ready) begin
          w_accept = 1'b1;
          w_next   = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // z_id moves together with z so both hold their last values outside OUT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr      <= '0;
      r_win      <= '0;
      r_xa       <= '0;
      r_ya       <= '0;
      r_op       <= '0;
      r_z        <= '0;
      r_z_id     <= '0;
      r_ops_done <= '0;
    end else begin
      if (w_load_win) begin
        r_win <= w_pick;
      end
      if (w_capture) begin
        r_xa <= w_x_sel;
        r_ya <= w_y_sel;
        r_op <= w_op_sel;
      end
      if (w_exec) begin
        r_z    <= w_alu;
        r_z_id <= r_win;
      end
      if (w_accept) begin
        r_ptr      <= (r_win == LAST_IDX) ? 3'd0 : r_win + 3'd1;
        r_ops_done <= r_ops_done + 8'd1;
      end
    end
  end

  assign z        = r_z;
  assign z_id     = r_z_id;
  assign ops_done = r_ops_done;

endmodule
